pwm_ramp_sched: RTL

//  Slew-rate scheduler between the SPI register file and the three PWM generators.
//  - Captures per-channel target duty writes (addresses 4'h0, 4'h4, 4'h8).
//  - Steps the applied duty toward each target by STEP on each prescaled tick.
//  - Channels are serviced round-robin through one shared add/compare datapath.
//  - Forces all applied duties to 0 while the motor enable is low.

---
 rtl/pwm_ramp_sched_if.sv | 19 +
 rtl/pwm_ramp_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sched_if.sv
// Register write bus from the SPI register file into the ramp scheduler.
// One-clk strobe qualifies address and data.
interface pwm_ramp_sched_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/pwm_ramp_sched.sv
// Slew-rate scheduler: steps three PWM duties toward their targets per tick.
// Optional RAMP_CURRENTLIMIT_EN: overcurrent forces a decrement toward 0.
module pwm_ramp_sched #(
  parameter int PRESCALE = 256,
  parameter int STEP     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  pwm_ramp_sched_if.slave   wr,
  input  logic              motorena,
  input  logic [2:0]        currentlimit,
  output logic [7:0]        duty0,
  output logic [7:0]        duty1,
  output logic [7:0]        duty2,
  output logic [2:0]        ramping
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CH0,
    S_CH1,
    S_CH2
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(PRESCALE - 1);
  localparam logic [8:0]  LP_STEP = 9'(STEP);

  state_t      r_state;
  logic [15:0] r_presc;
  logic [7:0]  r_target [3];
  logic [7:0]  r_duty   [3];

  logic       w_tick;
  logic [2:0] w_we;
  logic [1:0] w_idx;
  logic [7:0] w_cur;
  logic [7:0] w_tgt;
  logic       w_lim;
  logic [8:0] w_up;
  logic [8:0] w_dn;
  logic [7:0] w_next;

  assign w_tick = (r_presc == LP_LAST);

  always_comb begin
    w_we = '0;
    if (wr.wr_en) begin
      unique case (wr.wr_addr)
        4'h0:    w_we[0] = 1'b1;
        4'h4:    w_we[1] = 1'b1;
        4'h8:    w_we[2] = 1'b1;
        default: w_we    = '0;
      endcase
    end
  end

  always_comb begin
    w_idx = 2'd0;
    unique case (r_state)
      S_CH1:   w_idx = 2'd1;
      S_CH2:   w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_cur = r_duty[0];
    w_tgt = r_target[0];
    unique case (w_idx)
      2'd1: begin
        w_cur = r_duty[1];
        w_tgt = r_target[1];
      end
      2'd2: begin
        w_cur = r_duty[2];
        w_tgt = r_target[2];
      end
      default: begin
        w_cur = r_duty[0];
        w_tgt = r_target[0];
      end
    endcase
  end

`ifdef RAMP_CURRENTLIMIT_EN
  always_comb begin
    w_lim = 1'b0;
    unique case (w_idx)
      2'd1:    w_lim = currentlimit[1];
      2'd2:    w_lim = currentlimit[2];
      default: w_lim = currentlimit[0];
    endcase
  end
`else
  logic w_unused_cl;
  assign w_unused_cl = ^currentlimit;
  assign w_lim       = 1'b0;
`endif

  // 9-bit sums: bit 8 flags overflow past 0xFF or borrow below 0
  assign w_up = {1'b0, w_cur} + LP_STEP;
  assign w_dn = {1'b0, w_cur} - LP_STEP;

  always_comb begin
    w_next = w_cur;
    if (w_lim) begin
      w_next = w_dn[8] ? 8'h00 : w_dn[7:0];
    end else if (w_cur < w_tgt) begin
      w_next = (w_up > {1'b0, w_tgt}) ? w_tgt : w_up[7:0];
    end else if (w_cur > w_tgt) begin
      if (w_dn[8] || (w_dn[7:0] < w_tgt))
        w_next = w_tgt;
      else
        w_next = w_dn[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++)
        r_target[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (w_we[i])
          r_target[i] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      for (int i = 0; i < 3; i++)
        r_duty[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_tick) r_state <= S_CH0;
        S_CH0:  r_state <= S_CH1;
        S_CH1:  r_state <= S_CH2;
        S_CH2:  r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE) begin
        unique case (w_idx)
          2'd1:    r_duty[1] <= w_next;
          2'd2:    r_duty[2] <= w_next;
          default: r_duty[0] <= w_next;
        endcase
      end
      // disabled motor overrides any service in flight
      if (!motorena) begin
        for (int i = 0; i < 3; i++)
          r_duty[i] <= '0;
      end
    end
  end

  assign duty0 = r_duty[0];
  assign duty1 = r_duty[1];
  assign duty2 = r_duty[2];

`ifdef RAMP_CURRENTLIMIT_EN
  assign ramping[0] = (r_duty[0] != r_target[0]) | currentlimit[0];
  assign ramping[1] = (r_duty[1] != r_target[1]) | currentlimit[1];
  assign ramping[2] = (r_duty[2] != r_target[2]) | currentlimit[2];
`else
  assign ramping[0] = (r_duty[0] != r_target[0]);
  assign ramping[1] = (r_duty[1] != r_target[1]);
  assign ramping[2] = (r_duty[2] != r_target[2]);
`endif

endmodule
